// File: rtl/key_event_ctrl.sv
// Key event controller: turns debounced key levels into SHORT/LONG/REPEAT events,
// queues one pending event per key and arbitrates both keys onto one valid/ready port.
//
// state  | meaning
// S_IDLE | key released, waiting for a press
// S_HELD | key pressed, counting ms toward the LONG threshold
// S_LONG | LONG posted, counting ms between REPEAT events
module key_event_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key_In,
  input  logic       Evt_Ready,
  output logic       Evt_Valid,
  output logic       Evt_Key,
  output logic [1:0] Evt_Code,
  output logic [1:0] Evt_Drop
);

  localparam int              TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_TC     = TW'(TICK_DIV - 1);
  localparam logic [15:0]     LONG_TC     = 16'(LONG_MS);
  localparam logic [15:0]     REPEAT_TC   = 16'(REPEAT_MS);
  localparam logic [1:0]      CODE_SHORT  = 2'b01;
  localparam logic [1:0]      CODE_LONG   = 2'b10;
  localparam logic [1:0]      CODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} key_state_t;

  logic [1:0]    sync1, sync2, lvl_d;
  logic [1:0]    rise, fall;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  key_state_t    state   [2];
  logic [15:0]   ms_cnt  [2];
  logic [15:0]   cnt_inc [2];
  logic [1:0]    post;
  logic [1:0]    post_code [2];

  logic [1:0]    slot_vld;
  logic [1:0]    slot_code [2];
  logic          last_gnt;
  logic          load_out, gnt_en, gnt_key;
  logic [1:0]    gnt;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_d <= '0;
    end else begin
      sync1 <= Key_In;
      sync2 <= sync1;
      lvl_d <= sync2;
    end
  end

  assign rise = sync2 & ~lvl_d;
  assign fall = ~sync2 & lvl_d;

  assign tick = (tick_cnt == TICK_TC);

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) tick_cnt <= '0;
    else         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  // Release is checked before the threshold so a same-cycle release wins.
  always_comb begin
    post = '0;
    for (int k = 0; k < 2; k++) begin
      cnt_inc[k]   = ms_cnt[k] + 16'd1;
      post_code[k] = CODE_SHORT;
      case (state[k])
        S_HELD: begin
          if (fall[k]) begin
            post[k] = 1'b1;
          end else if (tick && cnt_inc[k] == LONG_TC) begin
            post[k]      = 1'b1;
            post_code[k] = CODE_LONG;
          end
        end
        S_LONG: begin
          if (!fall[k] && tick && cnt_inc[k] == REPEAT_TC) begin
            post[k]      = 1'b1;
            post_code[k] = CODE_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      for (int k = 0; k < 2; k++) begin
        state[k]  <= S_IDLE;
        ms_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (state[k])
          S_IDLE: begin
            if (rise[k]) begin
              state[k]  <= S_HELD;
              ms_cnt[k] <= '0;
            end
          end
          S_HELD: begin
            if (fall[k]) begin
              state[k] <= S_IDLE;
            end else if (tick) begin
              if (cnt_inc[k] == LONG_TC) begin
                state[k]  <= S_LONG;
                ms_cnt[k] <= '0;
              end else begin
                ms_cnt[k] <= cnt_inc[k];
              end
            end
          end
          S_LONG: begin
            if (fall[k]) begin
              state[k] <= S_IDLE;
            end else if (tick) begin
              ms_cnt[k] <= (cnt_inc[k] == REPEAT_TC) ? '0 : cnt_inc[k];
            end
          end
          default: state[k] <= S_IDLE;
        endcase
      end
    end
  end

  // Round-robin: on a tie the key not granted last wins; a lone pending slot always wins.
  assign load_out = ~Evt_Valid | Evt_Ready;
  assign gnt_key  = (slot_vld == 2'b11) ? ~last_gnt : slot_vld[1];
  assign gnt_en   = load_out & (|slot_vld);
  assign gnt      = gnt_en ? (gnt_key ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      slot_vld <= '0;
      Evt_Drop <= '0;
      for (int k = 0; k < 2; k++) slot_code[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (post[k]) begin
          if (!slot_vld[k] || gnt[k]) begin
            slot_vld[k]  <= 1'b1;
            slot_code[k] <= post_code[k];
          end
        end else if (gnt[k]) begin
          slot_vld[k] <= 1'b0;
        end
      end
      Evt_Drop <= post & slot_vld & ~gnt;
    end
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      Evt_Valid <= 1'b0;
      Evt_Key   <= 1'b0;
      Evt_Code  <= 2'b00;
      last_gnt  <= 1'b1;
    end else if (gnt_en) begin
      Evt_Valid <= 1'b1;
      Evt_Key   <= gnt_key;
      Evt_Code  <= slot_code[gnt_key];
      last_gnt  <= gnt_key;
    end else if (Evt_Ready) begin
      Evt_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with TICK_DIV=4, LONG_MS=10, REPEAT_MS=3.
module tb_key_event_ctrl;

  logic       Sys_CLK = 1'b0;
  logic       Sys_RST = 1'b1;
  logic [1:0] Key_In = 2'b00;
  logic       Evt_Ready = 1'b0;
  logic       Evt_Valid, Evt_Key;
  logic [1:0] Evt_Code, Evt_Drop;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [2:0] ev_q[$];
  int ev_c[$];
  int drop0 = 0;
  int drop1 = 0;

  key_event_ctrl #(.TICK_DIV(4), .LONG_MS(10), .REPEAT_MS(3)) dut (
    .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .Key_In(Key_In), .Evt_Ready(Evt_Ready),
    .Evt_Valid(Evt_Valid), .Evt_Key(Evt_Key), .Evt_Code(Evt_Code), .Evt_Drop(Evt_Drop)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  always @(posedge Sys_CLK) cyc <= cyc + 1;

  // Transfers and drop pulses, recorded mid-cycle with the cycle number of the preceding edge.
  always @(negedge Sys_CLK) begin
    if (!Sys_RST) begin
      if (Evt_Valid && Evt_Ready) begin
        ev_q.push_back({Evt_Key, Evt_Code});
        ev_c.push_back(cyc);
      end
      if (Evt_Drop[0]) drop0++;
      if (Evt_Drop[1]) drop1++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge Sys_CLK);
    #1;
  endtask

  function automatic logic [2:0] ev_at(int i);
    if (i < ev_q.size()) return ev_q[i];
    return 3'bxxx;
  endfunction

  function automatic int cyc_at(int i);
    if (i < ev_c.size()) return ev_c[i];
    return -1000;
  endfunction

  task automatic test_reset();
    int b, d;
    Sys_RST = 1'b1; Key_In = 2'b00; Evt_Ready = 1'b0;
    repeat (3) step();
    n_chk++; if (Evt_Valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", Evt_Valid); else n_pass++;
    n_chk++; if (Evt_Key !== 1'b0) $display("FAIL rst_key: got %b want 0", Evt_Key); else n_pass++;
    n_chk++; if (Evt_Code !== 2'b00) $display("FAIL rst_code: got %b want 00", Evt_Code); else n_pass++;
    n_chk++; if (Evt_Drop !== 2'b00) $display("FAIL rst_drop: got %b want 00", Evt_Drop); else n_pass++;
    b = ev_q.size(); d = drop0 + drop1;
    Sys_RST = 1'b0; Evt_Ready = 1'b1;
    repeat (200) step();
    n_chk++; if (ev_q.size() - b !== 0) $display("FAIL idle_events: got %0d want 0", ev_q.size() - b); else n_pass++;
    n_chk++; if (drop0 + drop1 - d !== 0) $display("FAIL idle_drops: got %0d want 0", drop0 + drop1 - d); else n_pass++;
  endtask

  task automatic test_short_press();
    int b;
    b = ev_q.size();
    Evt_Ready = 1'b1; Key_In = 2'b01;
    repeat (20) step();
    Key_In = 2'b00;
    repeat (3) step();
    n_chk++; if (Evt_Valid !== 1'b0) $display("FAIL short_early: valid got %b want 0 at 3 cycles", Evt_Valid); else n_pass++;
    step();
    n_chk++; if (Evt_Valid !== 1'b1) $display("FAIL short_latency: valid got %b want 1 at 4 cycles", Evt_Valid); else n_pass++;
    n_chk++; if (Evt_Key !== 1'b0) $display("FAIL short_key: got %b want 0", Evt_Key); else n_pass++;
    n_chk++; if (Evt_Code !== 2'b01) $display("FAIL short_code: got %b want 01", Evt_Code); else n_pass++;
    repeat (20) step();
    n_chk++; if (ev_q.size() - b !== 1) $display("FAIL short_count: got %0d want 1", ev_q.size() - b); else n_pass++;
    n_chk++; if (ev_at(b) !== 3'b001) $display("FAIL short_event: got %b want 001", ev_at(b)); else n_pass++;
  endtask

  task automatic test_long_repeat();
    int b, p, k;
    b = ev_q.size(); p = cyc;
    Evt_Ready = 1'b1; Key_In = 2'b10;
    repeat (80) step();
    Key_In = 2'b00;
    repeat (30) step();
    n_chk++; if (ev_q.size() - b !== 4) $display("FAIL long_count: got %0d want 4", ev_q.size() - b); else n_pass++;
    n_chk++; if (ev_at(b) !== 3'b110) $display("FAIL long_event: got %b want 110", ev_at(b)); else n_pass++;
    k = cyc_at(b) - p;
    n_chk++; if (k < 41 || k > 44) $display("FAIL long_time: got %0d cycles want 41..44", k); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_chk++; if (ev_at(b + i) !== 3'b111) $display("FAIL repeat_event%0d: got %b want 111", i, ev_at(b + i)); else n_pass++;
      n_chk++;
      if (cyc_at(b + i) - cyc_at(b + i - 1) !== 12)
        $display("FAIL repeat_gap%0d: got %0d want 12", i, cyc_at(b + i) - cyc_at(b + i - 1));
      else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    int b, n, bad;
    b = ev_q.size();
    Evt_Ready = 1'b0; Key_In = 2'b11;
    repeat (10) step();
    Key_In = 2'b00;
    n = 0;
    while (Evt_Valid !== 1'b1 && n < 20) begin step(); n++; end
    n_chk++; if (n !== 4) $display("FAIL arb_latency: got %0d cycles want 4", n); else n_pass++;
    n_chk++; if ({Evt_Key, Evt_Code} !== 3'b001) $display("FAIL arb_first: got %b want 001", {Evt_Key, Evt_Code}); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Evt_Valid !== 1'b1 || {Evt_Key, Evt_Code} !== 3'b001) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL arb_stable: got %0d unstable cycles want 0", bad); else n_pass++;
    Evt_Ready = 1'b1;
    repeat (10) step();
    n_chk++; if (ev_q.size() - b !== 2) $display("FAIL arb_count: got %0d want 2", ev_q.size() - b); else n_pass++;
    n_chk++; if (ev_at(b) !== 3'b001) $display("FAIL arb_order0: got %b want 001", ev_at(b)); else n_pass++;
    n_chk++; if (ev_at(b + 1) !== 3'b101) $display("FAIL arb_order1: got %b want 101", ev_at(b + 1)); else n_pass++;
    n_chk++;
    if (cyc_at(b + 1) - cyc_at(b) !== 1) $display("FAIL arb_b2b: got gap %0d want 1", cyc_at(b + 1) - cyc_at(b));
    else n_pass++;
  endtask

  task automatic test_drop();
    int b, d0, d1, n;
    b = ev_q.size(); d0 = drop0; d1 = drop1;
    Evt_Ready = 1'b0; Key_In = 2'b01;
    n = 0;
    while (Evt_Drop[0] !== 1'b1 && n < 120) begin step(); n++; end
    n_chk++; if (n < 64 || n > 67) $display("FAIL drop_time: got %0d cycles want 64..67", n); else n_pass++;
    n_chk++;
    if ({Evt_Valid, Evt_Key, Evt_Code} !== 4'b1010)
      $display("FAIL drop_out_held: got %b want 1010", {Evt_Valid, Evt_Key, Evt_Code});
    else n_pass++;
    Key_In = 2'b00;
    repeat (10) step();
    Evt_Ready = 1'b1;
    repeat (10) step();
    n_chk++; if (ev_q.size() - b !== 2) $display("FAIL drop_count: got %0d want 2", ev_q.size() - b); else n_pass++;
    n_chk++; if (ev_at(b) !== 3'b010) $display("FAIL drop_first: got %b want 010", ev_at(b)); else n_pass++;
    n_chk++; if (ev_at(b + 1) !== 3'b011) $display("FAIL drop_second: got %b want 011", ev_at(b + 1)); else n_pass++;
    n_chk++; if (drop0 - d0 !== 1) $display("FAIL drop_pulse0: got %0d cycles want 1", drop0 - d0); else n_pass++;
    n_chk++; if (drop1 - d1 !== 0) $display("FAIL drop_pulse1: got %0d cycles want 0", drop1 - d1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    Evt_Ready = 1'b0; Key_In = 2'b01;
    n = 0;
    while (Evt_Valid !== 1'b1 && n < 60) begin step(); n++; end
    n_chk++; if (Evt_Code !== 2'b10 || n >= 60) $display("FAIL mid_long: code %b after %0d cycles want 10", Evt_Code, n); else n_pass++;
    Sys_RST = 1'b1;
    #1;
    n_chk++;
    if ({Evt_Valid, Evt_Key, Evt_Code} !== 4'b0000)
      $display("FAIL mid_rst_clear: got %b want 0000", {Evt_Valid, Evt_Key, Evt_Code});
    else n_pass++;
    step();
    Sys_RST = 1'b0;
    n = 0;
    while (Evt_Valid !== 1'b1 && n < 80) begin step(); n++; end
    n_chk++; if (n !== 41) $display("FAIL mid_relong_time: got %0d cycles want 41", n); else n_pass++;
    n_chk++;
    if ({Evt_Key, Evt_Code} !== 3'b010) $display("FAIL mid_relong_event: got %b want 010", {Evt_Key, Evt_Code});
    else n_pass++;
    Key_In = 2'b00; Evt_Ready = 1'b1;
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_arbitration();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
